debug_dump_uart: RTL and testbench

DEBUG_DUMP_UART -- requirements
Module: debug_dump_uart

---
 rtl/debug_dump_uart.sv | 165 ++++++++++++++++
 tb/tb_debug_dump_uart.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_uart.sv
// Debug-bus snapshot dumper: on trigger, streams a 133-byte frame (sync, PC, x0..x31)
// out of an 8N1 UART transmitter, pulling each register word from the core debug bus.
module debug_dump_uart #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic [31:0] dbg_pc,
  input  logic [31:0] dbg_reg_data,
  output logic [4:0]  dbg_reg_sel,
  output logic        uart_tx,
  output logic        busy
);

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  ByteLast = 8'd132;
  localparam logic [7:0]  SyncByte = 8'hA5;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  byte_q, byte_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] word_q, word_d;
  logic [4:0]  sel_q, sel_d;
  logic        tx_q, tx_d;

  logic        bit_end;
  logic [7:0]  next_byte;
  logic [1:0]  lane;
  logic [31:0] src_word;
  logic [7:0]  cur_byte;

  // Bytes 4, 8, ..., 128 are the last byte of a word whose successor is a register.
  function automatic logic is_word_end(input logic [7:0] b);
    return (b[1:0] == 2'd0) && (b >= 8'd4) && (b <= 8'd128);
  endfunction

  assign bit_end   = (cnt_q == BitLast);
  assign next_byte = byte_q + 8'd1;

  // Byte 1 maps to lane 0 of the PC, byte 5 to lane 0 of x0, and so on.
  always_comb begin
    lane     = byte_q[1:0] - 2'd1;
    src_word = (byte_q <= 8'd4) ? pc_q : word_q;
    cur_byte = SyncByte;
    if (byte_q != 8'd0) begin
      unique case (lane)
        2'd0: cur_byte = src_word[7:0];
        2'd1: cur_byte = src_word[15:8];
        2'd2: cur_byte = src_word[23:16];
        2'd3: cur_byte = src_word[31:24];
        default: cur_byte = src_word[7:0];
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    pc_d    = pc_q;
    word_d  = word_q;
    sel_d   = sel_q;
    tx_d    = tx_q;

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d = StStart;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          pc_d    = dbg_pc;
          tx_d    = 1'b0;
        end
      end

      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = cur_byte[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 4'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = cur_byte[bit_q[2:0] + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      StStop: begin
        // The select was driven a whole byte earlier, so the data is long settled here.
        if ((cnt_q == 16'd0) && is_word_end(byte_q)) begin
          word_d = dbg_reg_data;
        end
        if (bit_end) begin
          cnt_d = '0;
          if (byte_q == ByteLast) begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end else begin
            state_d = StStart;
            byte_d  = next_byte;
            tx_d    = 1'b0;
            if (is_word_end(next_byte)) begin
              sel_d = 5'((next_byte - 8'd4) >> 2);
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      pc_q    <= '0;
      word_q  <= '0;
      sel_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx     = tx_q;
  assign busy        = (state_q != StIdle);
  assign dbg_reg_sel = sel_q;

endmodule

// File: tb/tb_debug_dump_uart.sv
// Bench for debug_dump_uart: scenario table plus reset and held-trigger sequences, each frame
// checked cycle by cycle against a level model and byte by byte against a decoded reference.
module tb_debug_dump_uart;

  localparam int Cpb         = 4;
  localparam int FrameBytes  = 133;
  localparam int FrameCycles = 10 * Cpb * FrameBytes;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] dbg_pc = '0;
  logic [31:0] dbg_reg_data = '0;
  logic [4:0]  dbg_reg_sel;
  logic        uart_tx;
  logic        busy;

  logic [31:0] regs [32];

  int checks = 0;
  int failures = 0;

  debug_dump_uart #(.CLKS_PER_BIT(Cpb)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trigger      (trigger),
    .dbg_pc       (dbg_pc),
    .dbg_reg_data (dbg_reg_data),
    .dbg_reg_sel  (dbg_reg_sel),
    .uart_tx      (uart_tx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Core register file: read data follows the select one clock later.
  always @(posedge clk) dbg_reg_data <= regs[dbg_reg_sel];

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] pc;
    bit          rand_regs;
    int          retrig_at;
    bit          pc_change;
    logic [31:0] pc_late;
    logic [31:0] exp_pc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic load_regs(input bit rnd);
    for (int k = 0; k < 32; k++) begin
      regs[k] = rnd ? $urandom : 32'h1111_1111 * (k % 16);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_frame(input logic [31:0] pc, input bit change, input logic [31:0] late,
                             input bit hold, input string tag);
    dbg_pc  = pc;
    trigger = 1'b1;
    @(negedge clk);
    check({tag, "_accept_tx"}, uart_tx, 1'b0);
    check({tag, "_accept_busy"}, busy, 1'b1);
    if (!hold) trigger = 1'b0;
    if (change) dbg_pc = late;
  endtask

  // Called at the negedge of frame cycle 0; returns at the first idle negedge.
  task automatic check_frame(input logic [31:0] pc_exp, input int retrig_at, input bit hold,
                             input string tag);
    logic [7:0] exp_bytes [FrameBytes];
    logic [7:0] rx;
    logic       lvl;
    int         wave_err;
    int         first_err;
    int         busy_err;
    int         b;
    int         p;
    exp_bytes[0] = 8'hA5;
    for (int j = 0; j < 4; j++) exp_bytes[1 + j] = pc_exp[8*j +: 8];
    for (int k = 0; k < 32; k++) begin
      for (int j = 0; j < 4; j++) exp_bytes[5 + 4*k + j] = regs[k][8*j +: 8];
    end
    wave_err  = 0;
    first_err = -1;
    busy_err  = 0;
    rx        = '0;
    for (int t = 0; t < FrameCycles; t++) begin
      b = t / (10 * Cpb);
      p = (t / Cpb) % 10;
      if (p == 0)      lvl = 1'b0;
      else if (p == 9) lvl = 1'b1;
      else             lvl = exp_bytes[b][p-1];
      if (uart_tx !== lvl) begin
        wave_err++;
        if (first_err < 0) first_err = t;
      end
      if (busy !== 1'b1) busy_err++;
      if (p >= 1 && p <= 8 && (t % Cpb) == Cpb / 2) rx[p-1] = uart_tx;
      if (p == 9 && (t % Cpb) == Cpb / 2) begin
        check($sformatf("%s_byte%0d", tag, b), {24'h0, rx}, {24'h0, exp_bytes[b]});
      end
      if (t == retrig_at) trigger = 1'b1;
      else if (!hold) trigger = 1'b0;
      @(negedge clk);
    end
    check({tag, "_wave_err_cycles"}, wave_err, 0);
    if (first_err >= 0) $display("  first waveform difference at frame cycle %0d", first_err);
    check({tag, "_busy_low_cycles"}, busy_err, 0);
    check({tag, "_end_busy"}, busy, 1'b0);
    check({tag, "_end_tx"}, uart_tx, 1'b1);
    check({tag, "_end_sel"}, dbg_reg_sel, 5'd31);
  endtask

  vec_t vecs [5];

  initial begin
    logic [31:0] rpc;
    logic [31:0] rpc2;
    rpc  = $urandom;
    rpc2 = $urandom;
    vecs[0] = '{32'h0000_1234, 1'b0, -1, 1'b0, 32'h0, 32'h0000_1234};
    vecs[1] = '{32'h0000_1234, 1'b0, 100, 1'b0, 32'h0, 32'h0000_1234};
    vecs[2] = '{32'h0000_1234, 1'b0, -1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234};
    vecs[3] = '{rpc, 1'b1, 50 + int'($urandom_range(0, 4000)), 1'b0, 32'h0, rpc};
    vecs[4] = '{rpc2, 1'b1, -1, 1'b1, $urandom, rpc2};

    load_regs(1'b0);
    trigger = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", uart_tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_sel", dbg_reg_sel, 5'd0);
    trigger = 1'b0;
    rst_n   = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle_busy", busy, 1'b0);

    for (int i = 0; i < 5; i++) begin
      load_regs(vecs[i].rand_regs);
      start_frame(vecs[i].pc, vecs[i].pc_change, vecs[i].pc_late, 1'b0, $sformatf("v%0d", i));
      check_frame(vecs[i].exp_pc, vecs[i].retrig_at, 1'b0, $sformatf("v%0d", i));
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_no_queued_frame", i), busy, 1'b0);
      check($sformatf("v%0d_sel_held", i), dbg_reg_sel, 5'd31);
    end

    // Reset mid-frame: outputs drop immediately, trigger ignored while held, no resume.
    load_regs(1'b0);
    start_frame(32'h0000_1234, 1'b0, 32'h0, 1'b0, "rst");
    repeat (2000) @(negedge clk);
    rst_n   = 1'b0;
    trigger = 1'b1;
    #1;
    check("rst_async_tx", uart_tx, 1'b1);
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_sel", dbg_reg_sel, 5'd0);
    repeat (2) @(negedge clk);
    check("rst_trigger_ignored", busy, 1'b0);
    trigger = 1'b0;
    rst_n   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_resume_busy", busy, 1'b0);
    check("rst_no_resume_tx", uart_tx, 1'b1);
    start_frame(32'h0000_1234, 1'b0, 32'h0, 1'b0, "rst_new");
    check_frame(32'h0000_1234, -1, 1'b0, "rst_new");

    // Trigger held high: one idle cycle, then the next frame starts.
    load_regs(1'b1);
    rpc = $urandom;
    start_frame(rpc, 1'b0, 32'h0, 1'b1, "hold1");
    check_frame(rpc, -1, 1'b1, "hold1");
    @(negedge clk);
    check("hold_restart_tx", uart_tx, 1'b0);
    check("hold_restart_busy", busy, 1'b1);
    trigger = 1'b0;
    check_frame(rpc, -1, 1'b0, "hold2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
